// File: rtl/osc_sweep_ctrl.sv
// osc_sweep_ctrl -- frequency-sweep sequencer for the digital sine oscillator.
//
// Holds a table of per-step coefficient pairs {2cos(b), sin(b)}. For each sweep
// step it pulses Ready with the step's coefficients on Init_1/Init_2, then
// produces sample-rate Enable strobes. The first Settle_Cfg samples of a step
// are discarded, and the following max(Num_Cfg,1) samples are flagged on
// Sample_Valid for the capture stage.
//
// Optional build macro: OSC_SWEEP_LOOP_EN -- the sweep wraps from Last_Step
// back to step 0 and repeats until Abort. Done pulses on each wrap.
//
// Ports:
//   Fg_CLK, Fg_RESET           clock, synchronous active-high reset
//   Cfg_We/Cfg_Addr            coefficient table write strobe / address
//   Cfg_Sin/Cfg_Cos2           sin(b), 2cos(b) in signed Q2.29
//   Last_Step                  final step index (inclusive)
//   Div_Cfg                    clocks per sample (0 acts as 1)
//   Settle_Cfg/Num_Cfg         discarded / measured samples per step (Num 0 acts as 1)
//   Start/Abort                sweep control
//   Ready/Enable               oscillator load pulse / advance strobe
//   Init_1/Init_2              sin(b) / 2cos(b) of the current step
//   Sample_Valid               oscillator output is a measurement sample
//   Step_Idx/Busy/Done         sweep status
module osc_sweep_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              Fg_CLK,
  input  logic              Fg_RESET,
  input  logic              Cfg_We,
  input  logic [ADDR_W-1:0] Cfg_Addr,
  input  logic [31:0]       Cfg_Sin,
  input  logic [31:0]       Cfg_Cos2,
  input  logic [ADDR_W-1:0] Last_Step,
  input  logic [DIV_W-1:0]  Div_Cfg,
  input  logic [CNT_W-1:0]  Settle_Cfg,
  input  logic [CNT_W-1:0]  Num_Cfg,
  input  logic              Start,
  input  logic              Abort,
  output logic              Ready,
  output logic              Enable,
  output logic [31:0]       Init_1,
  output logic [31:0]       Init_2,
  output logic              Sample_Valid,
  output logic [ADDR_W-1:0] Step_Idx,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, NEXT} state_t;

  state_t            state, state_nxt;
  logic [63:0]       tbl [0:(2**ADDR_W)-1];
  logic [DIV_W-1:0]  dcnt, div_term;
  logic [CNT_W:0]    scnt, num_eff, total;
  logic [ADDR_W-1:0] idx_nxt;
  logic              en_sched, go_next, done_go, sv_flag;

  // Table has no reset; contents are undefined until written.
  always_ff @(posedge Fg_CLK) begin
    if (Cfg_We) tbl[Cfg_Addr] <= {Cfg_Cos2, Cfg_Sin};
  end

  // Enable is registered, so the strobe is scheduled one cycle ahead: dcnt
  // counts from 0 in the LOAD cycle, and reaching div_term sets Enable for the
  // following cycle. scnt counts scheduled strobes. Because it is advanced at
  // scheduling time, its value when the strobe is scheduled is the
  // pre-increment count for that sample.
  always_comb begin
    div_term  = (Div_Cfg == '0) ? '0 : Div_Cfg - DIV_W'(1);
    num_eff   = (Num_Cfg == '0) ? (CNT_W+1)'(1) : {1'b0, Num_Cfg};
    total     = {1'b0, Settle_Cfg} + num_eff;
    en_sched  = (state == LOAD || state == RUN) && (dcnt >= div_term) &&
                (scnt < total) && !Abort;
    // Leave RUN in the cycle of the last Enable. The dcnt term also releases
    // the FSM if the count limit was lowered below the count already reached.
    go_next   = (state == RUN) && (scnt >= total) && (Enable || dcnt >= div_term);

    state_nxt = state;
    idx_nxt   = Step_Idx;
    done_go   = 1'b0;
    case (state)
      IDLE: if (Start) begin
        state_nxt = LOAD;
        idx_nxt   = '0;
      end
      LOAD: state_nxt = RUN;
      RUN:  if (go_next) state_nxt = NEXT;
      NEXT: begin
        if (Step_Idx == Last_Step) begin
          done_go = 1'b1;
`ifdef OSC_SWEEP_LOOP_EN
          state_nxt = LOAD;
          idx_nxt   = '0;
`else
          state_nxt = IDLE;
`endif
        end else begin
          state_nxt = LOAD;
          idx_nxt   = Step_Idx + ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (Abort) begin
      state_nxt = IDLE;
      idx_nxt   = Step_Idx;
      done_go   = 1'b0;
    end
  end

  always_ff @(posedge Fg_CLK) begin
    if (Fg_RESET) begin
      state        <= IDLE;
      Step_Idx     <= '0;
      Ready        <= 1'b0;
      Enable       <= 1'b0;
      Sample_Valid <= 1'b0;
      sv_flag      <= 1'b0;
      Done         <= 1'b0;
      Busy         <= 1'b0;
      Init_1       <= '0;
      Init_2       <= '0;
      dcnt         <= '0;
      scnt         <= '0;
    end else begin
      state        <= state_nxt;
      Step_Idx     <= idx_nxt;
      Ready        <= (state_nxt == LOAD);
      Done         <= done_go;
      Busy         <= (state_nxt != IDLE);
      Enable       <= en_sched;
      sv_flag      <= (scnt >= {1'b0, Settle_Cfg});
      Sample_Valid <= Enable && sv_flag && !Abort;
      if (state_nxt == LOAD) begin
        // Coefficients are latched here only, so table writes to the running
        // step are picked up at that step's next LOAD.
        Init_1 <= tbl[idx_nxt][31:0];
        Init_2 <= tbl[idx_nxt][63:32];
        dcnt   <= '0;
        scnt   <= '0;
      end else if (state == LOAD || state == RUN) begin
        dcnt <= (dcnt >= div_term) ? '0 : dcnt + DIV_W'(1);
        if (en_sched) scnt <= scnt + (CNT_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_osc_sweep_ctrl.sv
// Directed self-checking bench for osc_sweep_ctrl.
module tb_osc_sweep_ctrl;
  logic        Fg_CLK = 1'b0;
  logic        Fg_RESET = 1'b1;
  logic        Cfg_We = 1'b0;
  logic [3:0]  Cfg_Addr = '0;
  logic [31:0] Cfg_Sin = '0, Cfg_Cos2 = '0;
  logic [3:0]  Last_Step = '0;
  logic [15:0] Div_Cfg = '0, Settle_Cfg = '0, Num_Cfg = '0;
  logic        Start = 1'b0, Abort = 1'b0;
  logic        Ready, Enable, Sample_Valid, Busy, Done;
  logic [31:0] Init_1, Init_2;
  logic [3:0]  Step_Idx;

  int nchk = 0, nerr = 0;

  osc_sweep_ctrl #(.ADDR_W(4), .DIV_W(16), .CNT_W(16)) dut (
    .Fg_CLK(Fg_CLK), .Fg_RESET(Fg_RESET), .Cfg_We(Cfg_We), .Cfg_Addr(Cfg_Addr),
    .Cfg_Sin(Cfg_Sin), .Cfg_Cos2(Cfg_Cos2), .Last_Step(Last_Step),
    .Div_Cfg(Div_Cfg), .Settle_Cfg(Settle_Cfg), .Num_Cfg(Num_Cfg),
    .Start(Start), .Abort(Abort), .Ready(Ready), .Enable(Enable),
    .Init_1(Init_1), .Init_2(Init_2), .Sample_Valid(Sample_Valid),
    .Step_Idx(Step_Idx), .Busy(Busy), .Done(Done));

  always #5 Fg_CLK = ~Fg_CLK;

  logic [31:0] t_sin [0:2];
  logic [31:0] t_cos [0:2];

  task automatic tick();
    @(posedge Fg_CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] s, input logic [31:0] c);
    Cfg_We = 1'b1; Cfg_Addr = a; Cfg_Sin = s; Cfg_Cos2 = c;
    tick();
    Cfg_We = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy && n < 200) begin tick(); n++; end
    chk(tag, {79'd0, Busy}, 80'd0);
    tick();
  endtask

  function automatic logic [79:0] all_out();
    return {7'd0, Ready, Enable, Init_1, Init_2, Sample_Valid, Step_Idx, Busy, Done};
  endfunction

  initial begin
    logic [3:0] exp4;
    logic       ok;
    int         nen, dcyc;
    t_sin[0] = 32'h0800_0000; t_cos[0] = 32'h3FFF_0000;
    t_sin[1] = 32'h1000_0000; t_cos[1] = 32'h3EEE_0000;
    t_sin[2] = 32'h1800_0000; t_cos[2] = 32'h3DDD_0000;

    // Reset state
    tick(); tick();
    chk("reset_outputs", all_out(), 80'd0);
    Fg_RESET = 1'b0;
    tick();
    chk("post_reset_idle", all_out(), 80'd0);

    for (int i = 0; i < 3; i++) wr(4'(i), t_sin[i], t_cos[i]);

`ifdef OSC_SWEEP_LOOP_EN
    // Looping sweep: 0,1,0,1... with Done on each wrap
    Last_Step = 4'd1; Div_Cfg = 16'd0; Settle_Cfg = 16'd1; Num_Cfg = 16'd2;
    Start = 1'b1; tick(); Start = 1'b0;
    for (int c = 2; c <= 21; c++) begin
      tick();
      if (c == 6)  chk("loop_step1", {75'd0, Ready, Step_Idx}, {75'd0, 1'b1, 4'd1});
      if (c == 11) chk("loop_wrap1", {74'd0, Ready, Done, Step_Idx}, {74'd0, 2'b11, 4'd0});
      if (c == 16) chk("loop_step1b", {75'd0, Ready, Step_Idx}, {75'd0, 1'b1, 4'd1});
      if (c == 21) chk("loop_wrap2", {74'd0, Ready, Done, Step_Idx}, {74'd0, 2'b11, 4'd0});
    end
    chk("loop_busy", {79'd0, Busy}, 80'd1);
    Abort = 1'b1; tick(); Abort = 1'b0;
    chk("loop_abort", {78'd0, Busy, Enable}, 80'd0);
`else
    // Single step: Div=4, Settle=2, Num=3
    Last_Step = 4'd0; Div_Cfg = 16'd4; Settle_Cfg = 16'd2; Num_Cfg = 16'd3;
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t1_load", {15'd0, Ready, Enable, Busy, Init_1, Init_2},
        {15'd0, 3'b101, t_sin[0], t_cos[0]});
    ok = 1'b1;
    for (int c = 2; c <= 26; c++) begin
      tick();
      exp4 = {1'b0, (c >= 5 && c <= 21 && (c - 5) % 4 == 0),
              (c == 14 || c == 18 || c == 22), (c == 23)};
      if ({Ready, Enable, Sample_Valid, Done} !== exp4) begin
        chk($sformatf("t1_cyc%0d", c), {76'd0, Ready, Enable, Sample_Valid, Done}, {76'd0, exp4});
        ok = 1'b0;
      end
    end
    chk("t1_strobes", {79'd0, ok}, 80'd1);
    chk("t1_idle", {79'd0, Busy}, 80'd0);

    // Three steps, Div=0 (treated as 1), Settle=1, Num=2
    Last_Step = 4'd2; Div_Cfg = 16'd0; Settle_Cfg = 16'd1; Num_Cfg = 16'd2;
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t2_load0", {11'd0, Ready, Step_Idx, Init_1, Init_2}, {11'd0, 1'b1, 4'd0, t_sin[0], t_cos[0]});
    ok = 1'b1;
    for (int c = 2; c <= 18; c++) begin
      tick();
      exp4 = {3'b000, (c == 16)};
      for (int s = 0; s < 3; s++) begin
        if (c == 1 + 5*s) exp4[3] = 1'b1;
        if (c >= 2 + 5*s && c <= 4 + 5*s) exp4[2] = 1'b1;
        if (c == 4 + 5*s || c == 5 + 5*s) exp4[1] = 1'b1;
      end
      if ({Ready, Enable, Sample_Valid, Done} !== exp4) begin
        chk($sformatf("t2_cyc%0d", c), {76'd0, Ready, Enable, Sample_Valid, Done}, {76'd0, exp4});
        ok = 1'b0;
      end
      if (c == 6)  chk("t2_load1", {11'd0, Ready, Step_Idx, Init_1, Init_2}, {11'd0, 1'b1, 4'd1, t_sin[1], t_cos[1]});
      if (c == 11) chk("t2_load2", {11'd0, Ready, Step_Idx, Init_1, Init_2}, {11'd0, 1'b1, 4'd2, t_sin[2], t_cos[2]});
    end
    chk("t2_strobes", {79'd0, ok}, 80'd1);

    // Abort during third Enable of step 1 (cycle 9)
    Start = 1'b1; tick(); Start = 1'b0;
    for (int c = 2; c <= 9; c++) tick();
    chk("t3_pre_abort", {75'd0, Enable, Step_Idx}, {75'd0, 1'b1, 4'd1});
    Abort = 1'b1; tick(); Abort = 1'b0;
    chk("t3_abort", {76'd0, Busy, Enable, Ready, Done}, 80'd0);
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (Done !== 1'b0 || Busy !== 1'b0 || Enable !== 1'b0) ok = 1'b0;
    end
    chk("t3_no_done", {79'd0, ok}, 80'd1);
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t3_restart", {43'd0, Ready, Step_Idx, Init_1}, {43'd0, 1'b1, 4'd0, t_sin[0]});
    wait_idle("t3_finish");

    // Start pulse and table write mid-RUN
    Last_Step = 4'd0; Div_Cfg = 16'd4; Settle_Cfg = 16'd2; Num_Cfg = 16'd3;
    Start = 1'b1; tick(); Start = 1'b0;
    nen = 0; dcyc = 0;
    for (int c = 2; c <= 6; c++) begin tick(); if (Enable) nen++; end
    Start = 1'b1; Cfg_We = 1'b1; Cfg_Addr = 4'd0; Cfg_Sin = 32'h2000_0000; Cfg_Cos2 = 32'h3CCC_0000;
    tick();
    Start = 1'b0; Cfg_We = 1'b0;
    chk("t4_init_hold", {43'd0, Ready, Step_Idx, Init_1}, {43'd0, 1'b0, 4'd0, t_sin[0]});
    for (int c = 8; c <= 26; c++) begin
      tick();
      if (Enable) nen++;
      if (Done) dcyc = c;
    end
    chk("t4_enable_count", 80'(nen), 80'd5);
    chk("t4_done_cycle", 80'(dcyc), 80'd23);
    Start = 1'b1; tick(); Start = 1'b0;
    chk("t4_new_coef", {15'd0, Ready, Init_1, Init_2}, {15'd0, 1'b1, 32'h2000_0000, 32'h3CCC_0000});
    wait_idle("t4_finish");

    // Reset mid-RUN
    Start = 1'b1; tick(); Start = 1'b0;
    for (int c = 2; c <= 9; c++) tick();
    chk("t5_pre_reset", {78'd0, Enable, Busy}, {78'd0, 2'b11});
    Fg_RESET = 1'b1; tick();
    chk("t5_reset", all_out(), 80'd0);
    Fg_RESET = 1'b0; tick(); tick();
    chk("t5_stays_idle", {77'd0, Busy, Ready, Enable}, 80'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/osc_sweep_ctrl.md
# osc_sweep_ctrl

Frequency-sweep sequencer that drives the digital sine oscillator directly upstream of it. Holds a small table of per-frequency coefficient pairs (sin(b), 2cos(b)) and, for each sweep step, issues the oscillator's `Ready` load pulse with the step's coefficients. It then generates the sample-rate `Enable` strobes, discards a settling count of samples and flags the measurement samples for the downstream capture/DFT stage. Sits between the host/config register bank and the oscillator.

## Interface
Parameters:
- `ADDR_W`, 4: coefficient table address width; depth = 2^ADDR_W steps.
- `DIV_W`, 16: sample-rate divider width.
- `CNT_W`, 16: settle/measure sample counter width.

Ports:
- `Fg_CLK` in 1: single clock; all logic on its rising edge.
- `Fg_RESET` in 1: synchronous, active-high reset.
- `Cfg_We` in 1: table write strobe.
- `Cfg_Addr` in ADDR_W: table write address.
- `Cfg_Sin` in 32: sin(b), signed Q2.29, written to the table.
- `Cfg_Cos2` in 32: 2cos(b), signed Q2.29, written to the table.
- `Last_Step` in ADDR_W: index of the final sweep step, inclusive.
- `Div_Cfg` in DIV_W: clocks per sample; 0 is treated as 1.
- `Settle_Cfg` in CNT_W: samples discarded per step.
- `Num_Cfg` in CNT_W: measured samples per step; 0 is treated as 1.
- `Start` in 1: begin sweep; sampled only in IDLE.
- `Abort` in 1: terminate sweep.
- `Ready` out 1: oscillator load pulse.
- `Enable` out 1: oscillator advance strobe.
- `Init_1` out 32: sin(b) of the current step.
- `Init_2` out 32: 2cos(b) of the current step.
- `Sample_Valid` out 1: oscillator output is a measurement sample this cycle.
- `Step_Idx` out ADDR_W: current step index.
- `Busy` out 1: high in any state other than IDLE.
- `Done` out 1: one-cycle pulse at sweep end.

## Operation
- Table: 2^ADDR_W entries × 64 bits.
  - Write when `Cfg_We`=1; writes are allowed at any time.
  - A write to the current step takes effect only at that step's next LOAD, because `Init_1`/`Init_2` are latched at LOAD.
- States: IDLE, LOAD, RUN, NEXT.
- IDLE:
  - All strobes low.
  - On `Start`=1: `Step_Idx`←0, go to LOAD.
- LOAD, one cycle:
  - `Ready`=1.
  - `Init_1`/`Init_2` are registered from `table[Step_Idx]` and valid during this cycle.
  - Divider and sample counters cleared; go to RUN.
- RUN:
  - Divider counts 0…max(`Div_Cfg`,1)−1.
  - `Enable`=1 in the cycle where the divider equals its terminal value; the divider then wraps to 0.
  - The sample counter increments on each `Enable`.
  - The `Enable` that brings the count to `Settle_Cfg`+max(`Num_Cfg`,1) is the last one; the FSM moves to NEXT on the cycle after it.
- NEXT, one cycle:
  - If `Step_Idx`==`Last_Step`: `Done`=1, go to IDLE.
  - Otherwise: `Step_Idx`+1, go to LOAD.
- `Sample_Valid` is `Enable` delayed by one cycle, qualified by the pre-increment sample count ≥ `Settle_Cfg`. This aligns it with the oscillator's registered output update.
- `Abort`=1 in any state:
  - Next state is IDLE; `Enable`, `Ready` and `Done` are low from the next cycle.
  - No `Done` pulse is generated.
  - `Abort` has priority over `Start` and over all transitions.
- `Start` outside IDLE is ignored.
- Config inputs other than the table are sampled live; changing them mid-sweep is legal and takes effect at the next comparison.

## Timing
- Reset values: `Ready`=0, `Enable`=0, `Init_1`=0, `Init_2`=0, `Sample_Valid`=0, `Step_Idx`=0, `Busy`=0, `Done`=0, state IDLE, counters 0, table contents undefined.
- Reset is synchronous and overrides everything, including mid-sweep operation.
- `Start` sampled at edge k:
  - `Ready`=1 during cycle k+1.
  - First `Enable` during cycle k+1+max(`Div_Cfg`,1).
- `Ready` and `Enable` are never high in the same cycle.
- Every step issues exactly `Settle_Cfg`+max(`Num_Cfg`,1) `Enable` pulses and exactly max(`Num_Cfg`,1) `Sample_Valid` pulses.
- Step-to-step gap: last `Enable` → NEXT → LOAD (`Ready`) is 2 cycles.
- All outputs are registered; no combinational paths from inputs to outputs.

## Configuration
- `OSC_SWEEP_LOOP_EN` defined:
  - When NEXT sees `Step_Idx`==`Last_Step`, it pulses `Done`, sets `Step_Idx`←0 and goes to LOAD, so the sweep repeats until `Abort`.
  - `Busy` stays high throughout.
- `OSC_SWEEP_LOOP_EN` undefined: a single sweep, then IDLE, as described above.

## Test plan
- Single step: write table[0]=(0x0800_0000, 0x3FFF_0000); `Last_Step`=0, `Div_Cfg`=4, `Settle_Cfg`=2, `Num_Cfg`=3; `Start`.
  - `Ready` at k+1 with `Init_1`=0x0800_0000, `Init_2`=0x3FFF_0000.
  - 5 `Enable` pulses spaced 4 cycles apart, first at k+5.
  - 3 `Sample_Valid` pulses, each 1 cycle after `Enable` #3–#5.
  - `Done` 2 cycles after the last `Enable`.
- Three steps, `Last_Step`=2, `Div_Cfg`=0:
  - `Enable` every cycle.
  - `Ready` pulses carry table[0], table[1], table[2] in order.
  - 2-cycle gap between steps; one `Done` pulse.
- `Abort` asserted during the third `Enable` of step 1:
  - `Busy`=0 and `Enable`=0 from the next cycle.
  - No `Done`; a following `Start` restarts at step 0.
- `Start` pulsed mid-RUN is ignored, and a table write to the current step mid-RUN leaves `Init_1` unchanged until the next LOAD.
- `Fg_RESET` mid-RUN: all outputs 0 at the next edge.
- With `OSC_SWEEP_LOOP_EN` and `Last_Step`=1: steps go 0,1,0,1…, with a `Done` pulse each wrap; stops only on `Abort`.
